// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
// The comparator walks its operands one chunk per clock, starting at the top chunk.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  // Number of chunks needed to cover width bits; the top chunk may be partial.
  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CHUNK  = 3;
  localparam int DEF_NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);
  localparam int IDXW       = idx_width(DEF_NCHUNK);

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module chunk_cmp #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle signed/unsigned magnitude comparator with start/busy/valid handshake.
// Compares CHUNK bits per clock from the most significant end and exits at the first difference.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int LIDXW  = idx_width(NCHUNK);

  state_t           state, next_state;
  logic [WIDTH-1:0] op_a, op_b, next_a, next_b;
  logic [LIDXW-1:0] idx, next_idx;
  logic             next_valid, next_gt, next_eq, next_lt;

  logic [WIDTH-1:0] shift_a, shift_b, flip;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             c_gt, c_eq, c_lt;

  // Flipping the sign bit maps two's complement onto offset binary, so unsigned chunk order is signed order.
  assign flip = {signed_mode, {(WIDTH-1){1'b0}}};

  // Shifting in zeros leaves the partial top chunk zero-extended.
  assign shift_a = op_a >> (int'(idx) * CHUNK);
  assign shift_b = op_b >> (int'(idx) * CHUNK);
  assign chunk_a = shift_a[CHUNK-1:0];
  assign chunk_b = shift_b[CHUNK-1:0];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x  (chunk_a),
    .y  (chunk_b),
    .gt (c_gt),
    .eq (c_eq),
    .lt (c_lt)
  );

  assign busy = (state == CMP);

  always_comb begin
    next_state = state;
    next_a     = op_a;
    next_b     = op_b;
    next_idx   = idx;
    next_valid = 1'b0;
    next_gt    = gt;
    next_eq    = eq;
    next_lt    = lt;
    case (state)
      IDLE: begin
        if (start) begin
          next_a     = a ^ flip;
          next_b     = b ^ flip;
          next_idx   = LIDXW'(NCHUNK - 1);
          next_state = CMP;
        end
      end
      CMP: begin
        if (!c_eq) begin
          next_gt    = c_gt;
          next_eq    = 1'b0;
          next_lt    = c_lt;
          next_valid = 1'b1;
          next_state = IDLE;
        end else if (idx == '0) begin
          next_gt    = 1'b0;
          next_eq    = 1'b1;
          next_lt    = 1'b0;
          next_valid = 1'b1;
          next_state = IDLE;
        end else begin
          next_idx = idx - 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      idx   <= '0;
      valid <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      state <= next_state;
      op_a  <= next_a;
      op_b  <= next_b;
      idx   <= next_idx;
      valid <= next_valid;
      gt    <= next_gt;
      eq    <= next_eq;
      lt    <= next_lt;
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed self-checking bench for seq_mag_comparator at WIDTH=8, CHUNK=3.
module tb_seq_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] a, b;
  logic       busy, valid, gt, eq, lt;

  int checks = 0;
  int errors = 0;

  seq_mag_comparator #(.WIDTH(8), .CHUNK(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .valid       (valid),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  always #5 clk = ~clk;

  // Issues one request and waits (bounded) for valid; lat counts edges after the accepting edge.
  task automatic do_compare(input logic [7:0] va, input logic [7:0] vb, input logic sm,
                            output int lat, output int busy_cyc, output logic gtlt_seen);
    a = va; b = vb; signed_mode = sm; start = 1'b1;
    lat = 0; busy_cyc = 0; gtlt_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_cyc++;
      if (gt || lt) gtlt_seen = 1'b1;
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) $display("[TB] timeout waiting for valid a=%h b=%h", va, vb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #12;
    checks++;
    if ({busy, valid, gt, eq, lt} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b exp=00000", {busy, valid, gt, eq, lt});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_early_exit();
    int lat, bc; logic seen;
    do_compare(8'hA5, 8'h25, 1'b0, lat, bc, seen);
    checks++;
    if ({gt, eq, lt} !== 3'b100) begin
      errors++; $display("[TB] FAIL early_exit_result got=%b exp=100", {gt, eq, lt});
    end
    checks++;
    if (lat !== 1 || bc !== 1) begin
      errors++; $display("[TB] FAIL early_exit_timing lat=%0d busy=%0d exp lat=1 busy=1", lat, bc);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || gt !== 1'b1) begin
      errors++; $display("[TB] FAIL valid_one_cycle valid=%b gt=%b exp valid=0 gt=1", valid, gt);
    end
  endtask

  task automatic test_full_scan();
    int lat, bc; logic seen;
    do_compare(8'h3A, 8'h3C, 1'b0, lat, bc, seen);
    checks++;
    if ({gt, eq, lt} !== 3'b001) begin
      errors++; $display("[TB] FAIL full_scan_result got=%b exp=001", {gt, eq, lt});
    end
    checks++;
    if (lat !== 3 || bc !== 3) begin
      errors++; $display("[TB] FAIL full_scan_timing lat=%0d busy=%0d exp lat=3 busy=3", lat, bc);
    end
  endtask

  task automatic test_equal();
    int lat, bc; logic seen;
    do_compare(8'h3C, 8'h3C, 1'b0, lat, bc, seen);
    checks++;
    if ({gt, eq, lt} !== 3'b010 || lat !== 3) begin
      errors++; $display("[TB] FAIL equal_3c got=%b lat=%0d exp=010 lat=3", {gt, eq, lt}, lat);
    end
    do_compare(8'h00, 8'h00, 1'b0, lat, bc, seen);
    checks++;
    if ({gt, eq, lt} !== 3'b010 || lat !== 3 || seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL equal_00 got=%b lat=%0d gtlt_seen=%b exp=010 lat=3 seen=0", {gt, eq, lt}, lat, seen);
    end
  endtask

  task automatic test_sign_mode();
    int lat, bc; logic seen;
    do_compare(8'h80, 8'h7F, 1'b1, lat, bc, seen);
    checks++;
    if ({gt, eq, lt} !== 3'b001 || lat !== 1) begin
      errors++; $display("[TB] FAIL signed_80_7f got=%b lat=%0d exp=001 lat=1", {gt, eq, lt}, lat);
    end
    do_compare(8'h80, 8'h7F, 1'b0, lat, bc, seen);
    checks++;
    if ({gt, eq, lt} !== 3'b100 || lat !== 1) begin
      errors++; $display("[TB] FAIL unsigned_80_7f got=%b lat=%0d exp=100 lat=1", {gt, eq, lt}, lat);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    a = 8'h3A; b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      if (valid) begin
        lat = k - 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({gt, eq, lt} !== 3'b001 || lat !== 3) begin
      errors++; $display("[TB] FAIL start_while_busy got=%b lat=%0d exp=001 lat=3", {gt, eq, lt}, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic seen;
    do_compare(8'h3A, 8'h3C, 1'b0, lat, bc, seen);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_valid_cycle busy=%b valid=%b exp busy=0 valid=1", busy, valid);
    end
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_accept busy=%b valid=%b exp busy=1 valid=0", busy, valid);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b1 || {gt, eq, lt} !== 3'b100) begin
      errors++; $display("[TB] FAIL b2b_result valid=%b got=%b exp valid=1 100", valid, {gt, eq, lt});
    end
  endtask

  task automatic test_reset_mid_op();
    logic saw_valid;
    a = 8'h3A; b = 8'h3C; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, gt, eq, lt} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_mid_op got=%b exp=00000", {busy, valid, gt, eq, lt});
    end
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (valid || busy) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0 || {gt, eq, lt} !== 3'b000) begin
      errors++; $display("[TB] FAIL post_reset_quiet activity=%b flags=%b exp activity=0 flags=000", saw_valid, {gt, eq, lt});
    end
  endtask

  initial begin
    test_reset();
    test_early_exit();
    test_full_scan();
    test_equal();
    test_sign_mode();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
